// File: rtl/hdlc_deframer_if.sv
// hdlc_deframer_if: decoded bit stream in, payload bytes and frame delimiters out
interface hdlc_deframer_if;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_start;
  logic       frame_end;
  logic       crc_ok;
  logic       frame_err;
  modport master (
    output bit_in, bit_valid,
    input  byte_out, byte_valid, frame_start, frame_end, crc_ok, frame_err
  );
  modport slave (
    input  bit_in, bit_valid,
    output byte_out, byte_valid, frame_start, frame_end, crc_ok, frame_err
  );
endinterface

// File: rtl/hdlc_deframer.sv
// hdlc_deframer: HDLC receive stage - flag/abort detection, destuffing, byte assembly, FCS check
module hdlc_deframer #(
  parameter int MAX_BYTES = 64
) (
  input logic             sclk,
  input logic             rst_n,
  hdlc_deframer_if.slave  bus
);
  localparam int NW = $clog2(MAX_BYTES + 4);
  typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;
  state_t state, state_n;
  logic [2:0] ones, ones_n, bit_cnt, bit_cnt_n;
  logic [7:0] sr, sr_n, shifted, f0, f0_n, f1, f1_n, byte_n;
  logic [15:0] crc, crc_n;
  logic [NW-1:0] nbytes, nbytes_n;
  logic [1:0] fcnt, fcnt_n;
  logic started, started_n, bv_n, fs_n, fe_n, ok_n, err_n;
  logic abort_b, flag_b, data_b, good;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'h8408 : r >> 1;
    return r;
  endfunction
  assign abort_b = ones >= 3'd6 && bus.bit_in;
  assign flag_b  = ones == 3'd6 && !bus.bit_in;
  assign data_b  = !abort_b && !flag_b && ones != 3'd5;
  assign shifted = {bus.bit_in, sr[7:1]};
  assign good    = bit_cnt == 3'd6 && nbytes >= NW'(3) && crc == 16'hF0B8;
  // State, per-frame bookkeeping and registered outputs
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= HUNT;
      ones            <= '0;
      bit_cnt         <= '0;
      sr              <= '0;
      crc             <= 16'hFFFF;
      nbytes          <= '0;
      f0              <= '0;
      f1              <= '0;
      fcnt            <= '0;
      started         <= 1'b0;
      bus.byte_out    <= '0;
      bus.byte_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_end   <= 1'b0;
      bus.crc_ok      <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      state           <= state_n;
      ones            <= ones_n;
      bit_cnt         <= bit_cnt_n;
      sr              <= sr_n;
      crc             <= crc_n;
      nbytes          <= nbytes_n;
      f0              <= f0_n;
      f1              <= f1_n;
      fcnt            <= fcnt_n;
      started         <= started_n;
      bus.byte_out    <= byte_n;
      bus.byte_valid  <= bv_n;
      bus.frame_start <= fs_n;
      bus.frame_end   <= fe_n;
      bus.crc_ok      <= ok_n;
      bus.frame_err   <= err_n;
    end
  end
  // Bit classification, frame state machine, two-byte FCS hold and emission
  always_comb begin
    state_n   = state;
    ones_n    = ones;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    crc_n     = crc;
    nbytes_n  = nbytes;
    f0_n      = f0;
    f1_n      = f1;
    fcnt_n    = fcnt;
    started_n = started;
    byte_n    = bus.byte_out;
    bv_n      = 1'b0;
    fs_n      = 1'b0;
    fe_n      = 1'b0;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    if (bus.bit_valid) begin
      ones_n = bus.bit_in ? (ones == 3'd7 ? 3'd7 : ones + 3'd1) : 3'd0;
      case (state)
        SYNC: begin
          if (abort_b) state_n = HUNT;
          else if (data_b) begin
            state_n   = DATA;
            sr_n      = shifted;
            bit_cnt_n = 3'd1;
            crc_n     = 16'hFFFF;
          end
        end
        DATA: begin
          if (abort_b) begin
            fe_n    = nbytes != '0;
            err_n   = nbytes != '0;
            state_n = HUNT;
          end else if (flag_b) begin
            fe_n    = nbytes != '0;
            ok_n    = nbytes != '0 && good;
            err_n   = nbytes != '0 && !good;
            state_n = SYNC;
          end else if (data_b) begin
            sr_n      = shifted;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              crc_n    = crc_byte(crc, shifted);
              nbytes_n = nbytes + NW'(1);
              if (nbytes_n == NW'(MAX_BYTES + 3)) begin
                fe_n    = 1'b1;
                err_n   = 1'b1;
                state_n = HUNT;
              end else if (fcnt == 2'd2) begin
                byte_n    = f0;
                bv_n      = 1'b1;
                fs_n      = !started;
                started_n = 1'b1;
                f0_n      = f1;
                f1_n      = shifted;
              end else begin
                f0_n   = fcnt == 2'd0 ? shifted : f0;
                f1_n   = fcnt == 2'd1 ? shifted : f1;
                fcnt_n = fcnt + 2'd1;
              end
            end
          end
        end
        default: state_n = flag_b ? SYNC : HUNT;
      endcase
      if (state_n != DATA) begin
        bit_cnt_n = '0;
        sr_n      = '0;
        crc_n     = 16'hFFFF;
        nbytes_n  = '0;
        fcnt_n    = '0;
        started_n = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hdlc_deframer.sv
// tb_hdlc_deframer: directed and randomized frames checked against a frame-level reference model
module tb_hdlc_deframer;
  localparam int MAXB = 4;
  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int gap = 0;
  logic [11:0] got[$];
  logic [11:0] exp[$];
  hdlc_deframer_if bus ();
  hdlc_deframer #(.MAX_BYTES(MAXB)) dut (.sclk(sclk), .rst_n(rst_n), .bus(bus));
  always #5 sclk = ~sclk;
  // Record every output event: byte {01,start,0,byte} or end {10,0..,ok,err}
  always @(negedge sclk) begin
    if (rst_n && bus.byte_valid) got.push_back({2'b01, bus.frame_start, 1'b0, bus.byte_out});
    if (rst_n && bus.frame_end) got.push_back({2'b10, 8'h00, bus.crc_ok, bus.frame_err});
    if (rst_n && bus.frame_start && !bus.byte_valid) got.push_back(12'hFFF);
  end
  function automatic logic [15:0] fcs_of(input logic [7:0] q[$], input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ q[i][b]) ? (c >> 1) ^ 16'h8408 : c >> 1;
    return ~c;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask
  task automatic send_bit(input logic b);
    bus.bit_in = b;
    bus.bit_valid = 1'b1;
    @(posedge sclk);
    #1;
    bus.bit_valid = 1'b0;
    idle(gap);
  endtask
  task automatic send_raw(input logic [7:0] v);
    for (int b = 0; b < 8; b++) send_bit(v[b]);
  endtask
  task automatic send_stuffed(input logic db[$]);
    int run;
    run = 0;
    foreach (db[i]) begin
      send_bit(db[i]);
      run = db[i] ? run + 1 : 0;
      if (run == 5) begin
        send_bit(1'b0);
        run = 0;
      end
    end
  endtask
  // Frame-level expectation: data bits (plus the flag's leading 0 and five 1s) chunk into bytes;
  // all but the last two are delivered; FCS must match and the frame must be octet aligned
  task automatic model(input logic db[$], input bit ab);
    logic bits[$];
    logic [7:0] bb[$];
    logic [7:0] v;
    int nb;
    bit ok;
    bits = db;
    if (!ab) begin
      bits.push_back(1'b0);
      repeat (5) bits.push_back(1'b1);
    end
    nb = bits.size() / 8;
    for (int k = 0; k < nb; k++) begin
      for (int b = 0; b < 8; b++) v[b] = bits[8*k+b];
      bb.push_back(v);
    end
    if (nb >= MAXB + 3) begin
      for (int i = 0; i < MAXB; i++) exp.push_back({2'b01, i == 0, 1'b0, bb[i]});
      exp.push_back({2'b10, 8'h00, 2'b01});
      return;
    end
    for (int i = 0; i < nb - 2; i++) exp.push_back({2'b01, i == 0, 1'b0, bb[i]});
    if (nb >= 1) begin
      ok = 1'b0;
      if (!ab && bits.size() % 8 == 6 && nb >= 3) ok = ({bb[nb-1], bb[nb-2]} == fcs_of(bb, nb - 2));
      exp.push_back({2'b10, 8'h00, ok, !ok});
    end
  endtask
  task automatic run_frame(input logic [7:0] pl[$], input bit add_fcs, input bit corrupt,
                           input int extra_n, input logic [7:0] extra, input bit abort_end);
    logic [7:0] by[$];
    logic db[$];
    logic [15:0] f;
    by = pl;
    if (add_fcs) begin
      f = fcs_of(pl, pl.size());
      if (corrupt) f[3] = ~f[3];
      by.push_back(f[7:0]);
      by.push_back(f[15:8]);
    end
    foreach (by[i]) for (int b = 0; b < 8; b++) db.push_back(by[i][b]);
    for (int b = 0; b < extra_n; b++) db.push_back(extra[b]);
    send_raw(8'h7E);
    send_stuffed(db);
    if (abort_end) repeat (7) send_bit(1'b1);
    else send_raw(8'h7E);
    model(db, abort_end);
    idle(4);
  endtask
  task automatic check_q(input string tag);
    logic [11:0] obs;
    checks++;
    assert (got.size() == exp.size()) else begin
      errors++;
      $error("FAIL %s event_count observed=%0d expected=%0d", tag, got.size(), exp.size());
    end
    foreach (exp[i]) begin
      obs = i < got.size() ? got[i] : 12'bx;
      checks++;
      assert (obs === exp[i]) else begin
        errors++;
        $error("FAIL %s event%0d observed=%h expected=%h", tag, i, obs, exp[i]);
      end
    end
    got.delete();
    exp.delete();
  endtask
  task automatic check_zero(input string tag);
    logic [12:0] o;
    o = {bus.byte_out, bus.byte_valid, bus.frame_start, bus.frame_end, bus.crc_ok, bus.frame_err};
    checks++;
    assert (o === 13'h0) else begin
      errors++;
      $error("FAIL %s outputs observed=%h expected=0", tag, o);
    end
  endtask
  initial begin
    logic [7:0] pl[$];
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);
    check_zero("post_reset");
    gap = 3;
    pl = '{8'h12, 8'h34};
    run_frame(pl, 1, 0, 0, 8'h00, 0);
    check_q("good_1234");
    gap = 0;
    pl = '{8'hFF, 8'h7E};
    run_frame(pl, 1, 0, 0, 8'h00, 0);
    check_q("stuff_ff7e");
    run_frame(pl, 1, 1, 0, 8'h00, 0);
    check_q("bad_fcs");
    gap = 1;
    pl = '{8'hA5, 8'h3C};
    run_frame(pl, 0, 0, 0, 8'h00, 1);
    check_q("abort");
    send_raw(8'h55);
    send_raw(8'h00);
    idle(3);
    check_q("after_abort");
    send_raw(8'h7E);
    send_raw(8'h7E);
    send_raw(8'h7E);
    idle(3);
    check_q("flags_only");
    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(pl, 0, 0, 3, 8'h02, 0);
    check_q("misaligned");
    pl = '{8'h5A};
    run_frame(pl, 0, 0, 0, 8'h00, 0);
    check_q("too_short");
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    run_frame(pl, 1, 0, 0, 8'h00, 0);
    check_q("too_long");
    gap = 1;
    send_raw(8'h7E);
    send_raw(8'hAA);
    send_raw(8'h55);
    rst_n = 1'b0;
    idle(2);
    check_zero("reset_mid");
    rst_n = 1'b1;
    idle(2);
    check_q("reset_mid_events");
    pl = '{8'hC3, 8'h00, 8'h7F};
    run_frame(pl, 1, 0, 0, 8'h00, 0);
    check_q("after_reset");
    for (int r = 0; r < 8; r++) begin
      gap = $urandom_range(0, 3);
      pl.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        pl.push_back($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
      run_frame(pl, 1, $urandom_range(0, 3) == 0, 0, 8'h00, 0);
      check_q("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
